// File: rtl/onehot_state_reg.sv
`timescale 1ns/1ps
// onehot_state_reg
// One-hot micro-state register for the M machine control unit. Loads the
// next-state vector on en, returns to the fetch state on flush or reset,
// rejects non-one-hot vectors by recovering to the fetch state, and keeps a
// registered binary index, an entry pulse and a saturating dwell counter.
module onehot_state_reg #(
   parameter int N_STATES  = 13,
   parameter int RESET_IDX = 0,
   parameter int CNT_W     = 8,
   localparam int IDX_W    = $clog2(N_STATES)
) (
   input  logic                clk,
   input  logic                preset,
   input  logic                en,
   input  logic                flush,
   input  logic                clr_err,
   input  logic [N_STATES-1:0] d,
   output logic [N_STATES-1:0] q,
   output logic [IDX_W-1:0]    state_idx,
   output logic                entered,
   output logic [CNT_W-1:0]    dwell,
   output logic                fault,
   output logic                illegal
);

   localparam logic [N_STATES-1:0] RESET_VEC = N_STATES'(1) << RESET_IDX;
   localparam logic [IDX_W-1:0]    RESET_BIN = IDX_W'(RESET_IDX);
   localparam logic [CNT_W-1:0]    DWELL_MAX = '1;

   logic             d_legal;
   logic [IDX_W-1:0] d_idx;
   logic             recover;
   logic [CNT_W-1:0] dwell_inc;

   // Legality of d (exactly one bit set) and its binary index; the index is
   // only consumed when d is legal, so OR-ing indices of set bits is enough.
   always_comb begin
      d_legal = (d != '0) && ((d & (d - N_STATES'(1))) == '0);
      d_idx   = '0;
      for (int i = 0; i < N_STATES; i++) begin
         if (d[i]) d_idx = d_idx | IDX_W'(i);
      end
   end

   // Recovery case and saturating dwell increment.
   always_comb begin
      recover   = ~flush & en & ~d_legal;
      dwell_inc = (dwell == DWELL_MAX) ? dwell : dwell + CNT_W'(1);
   end

   // State register with flush > legal load > recovery > hold priority.
   always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
         q         <= RESET_VEC;
         state_idx <= RESET_BIN;
         entered   <= 1'b0;
         dwell     <= '0;
         fault     <= 1'b0;
      end else begin
         entered <= 1'b0;
         fault   <= 1'b0;
         if (flush) begin
            q         <= RESET_VEC;
            state_idx <= RESET_BIN;
            entered   <= 1'b1;
            dwell     <= '0;
         end else if (en && d_legal) begin
            q         <= d;
            state_idx <= d_idx;
            if (d != q) begin
               entered <= 1'b1;
               dwell   <= '0;
            end else begin
               dwell <= dwell_inc;
            end
         end else if (en) begin
            q         <= RESET_VEC;
            state_idx <= RESET_BIN;
            entered   <= 1'b1;
            dwell     <= '0;
            fault     <= 1'b1;
         end else begin
            dwell <= dwell_inc;
         end
      end
   end

   // Sticky illegal flag; a rejection on the same edge beats clr_err.
   always_ff @(posedge clk or posedge preset) begin
      if (preset) begin
         illegal <= 1'b0;
      end else if (recover) begin
         illegal <= 1'b1;
      end else if (clr_err) begin
         illegal <= 1'b0;
      end
   end

endmodule

// File: tb/tb_onehot_state_reg.sv
`timescale 1ns/1ps
// Bench for onehot_state_reg: instance a (13 states, reset bit 0, 3-bit dwell)
// and instance b (5 states, reset bit 3, 8-bit dwell), each checked against a
// behavioural model through an expectation queue.
module tb_onehot_state_reg;

   typedef struct packed {
      logic [12:0] q;
      logic [3:0]  idx;
      logic        entered;
      logic [7:0]  dwell;
      logic        fault;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        preset_a = 1'b1, en_a = 1'b0, flush_a = 1'b0, clr_a = 1'b0;
   logic [12:0] d_a = '0;
   logic [12:0] q_a;
   logic [3:0]  idx_a;
   logic        ent_a, flt_a, ill_a;
   logic [2:0]  dwell_a;

   logic        preset_b = 1'b1, en_b = 1'b0, flush_b = 1'b0, clr_b = 1'b0;
   logic [4:0]  d_b = '0;
   logic [4:0]  q_b;
   logic [2:0]  idx_b;
   logic        ent_b, flt_b, ill_b;
   logic [7:0]  dwell_b;

   int errors = 0;
   int checks = 0;

   exp_t sb0[$];
   exp_t sb1[$];

   logic [12:0] mq [2];
   int          mdw [2];
   bit          mill [2];

   always #5 clk = ~clk;

   onehot_state_reg #(.N_STATES(13), .RESET_IDX(0), .CNT_W(3)) dut_a (
      .clk(clk), .preset(preset_a), .en(en_a), .flush(flush_a), .clr_err(clr_a),
      .d(d_a), .q(q_a), .state_idx(idx_a), .entered(ent_a), .dwell(dwell_a),
      .fault(flt_a), .illegal(ill_a));

   onehot_state_reg #(.N_STATES(5), .RESET_IDX(3), .CNT_W(8)) dut_b (
      .clk(clk), .preset(preset_b), .en(en_b), .flush(flush_b), .clr_err(clr_b),
      .d(d_b), .q(q_b), .state_idx(idx_b), .entered(ent_b), .dwell(dwell_b),
      .fault(flt_b), .illegal(ill_b));

   function automatic void model_reset(int k);
      mq[k]   = 13'(1) << ((k == 0) ? 0 : 3);
      mdw[k]  = 0;
      mill[k] = 1'b0;
   endfunction

   function automatic exp_t model_step(int k, bit en_v, bit fl_v, bit clr_v, logic [12:0] d_v);
      exp_t        e;
      int          n   = (k == 0) ? 13 : 5;
      int          ri  = (k == 0) ? 0 : 3;
      int          sat = (k == 0) ? 7 : 255;
      logic [12:0] rv  = 13'(1) << ri;
      logic [12:0] dm  = d_v & ((13'(1) << n) - 13'(1));
      bit          rec = 1'b0;
      e = '0;
      if (fl_v) begin
         mq[k] = rv;
         mdw[k] = 0;
         e.entered = 1'b1;
      end else if (en_v && $countones(dm) == 1) begin
         if (dm != mq[k]) begin
            e.entered = 1'b1;
            mdw[k] = 0;
         end else if (mdw[k] < sat) begin
            mdw[k]++;
         end
         mq[k] = dm;
      end else if (en_v) begin
         rec = 1'b1;
         mq[k] = rv;
         mdw[k] = 0;
         e.entered = 1'b1;
         e.fault = 1'b1;
      end else if (mdw[k] < sat) begin
         mdw[k]++;
      end
      if (rec) mill[k] = 1'b1;
      else if (clr_v) mill[k] = 1'b0;
      e.q = mq[k];
      for (int i = 0; i < 13; i++) if (mq[k][i]) e.idx = 4'(i);
      e.dwell = 8'(mdw[k]);
      e.illegal = mill[k];
      return e;
   endfunction

   function automatic exp_t observe(int k);
      exp_t o;
      if (k == 0) begin
         o.q = q_a; o.idx = idx_a; o.entered = ent_a;
         o.dwell = {5'b0, dwell_a}; o.fault = flt_a; o.illegal = ill_a;
      end else begin
         o.q = {8'b0, q_b}; o.idx = {1'b0, idx_b}; o.entered = ent_b;
         o.dwell = dwell_b; o.fault = flt_b; o.illegal = ill_b;
      end
      return o;
   endfunction

   task automatic drive(int k, bit en_v, bit fl_v, bit clr_v, logic [12:0] d_v);
      if (k == 0) begin
         en_a = en_v; flush_a = fl_v; clr_a = clr_v; d_a = d_v;
         sb0.push_back(model_step(0, en_v, fl_v, clr_v, d_v));
      end else begin
         en_b = en_v; flush_b = fl_v; clr_b = clr_v; d_b = d_v[4:0];
         sb1.push_back(model_step(1, en_v, fl_v, clr_v, d_v));
      end
   endtask

   task automatic test_reset();
      exp_t e, o;
      checks++;
      if ({q_a, idx_a, dwell_a, ill_a, ent_a, flt_a} !== {13'h0001, 4'd0, 3'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_initial got q=%h idx=%0d dw=%0d ill=%b ent=%b flt=%b want q=0001 idx=0 dw=0 ill=0 ent=0 flt=0",
                  q_a, idx_a, dwell_a, ill_a, ent_a, flt_a);
      end
      preset_a = 1'b0;
      model_reset(0);
      for (int i = 0; i < 3; i++) begin
         if (i == 0) drive(0, 1, 0, 0, 13'h0006);
         else if (i == 1) drive(0, 1, 0, 0, 13'h0020);
         else drive(0, 0, 0, 0, 13'h0000);
         @(posedge clk); #1;
         e = sb0.pop_front(); o = observe(0); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_prep[%0d] got q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b want q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b",
                     i, o.q, o.idx, o.entered, o.dwell, o.fault, o.illegal, e.q, e.idx, e.entered, e.dwell, e.fault, e.illegal);
         end
      end
      #2;
      preset_a = 1'b1;
      model_reset(0);
      #1;
      checks++;
      if ({q_a, idx_a, dwell_a, ill_a, ent_a, flt_a} !== {13'h0001, 4'd0, 3'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_async got q=%h idx=%0d dw=%0d ill=%b ent=%b flt=%b want q=0001 idx=0 dw=0 ill=0 ent=0 flt=0",
                  q_a, idx_a, dwell_a, ill_a, ent_a, flt_a);
      end
      @(posedge clk); #1;
      preset_a = 1'b0;
   endtask

   task automatic test_sequence();
      exp_t        e, o;
      logic [12:0] d_t [3] = '{13'h0002, 13'h0004, 13'h0004};
      bit          ent_l [3] = '{1'b1, 1'b1, 1'b0};
      int          dw_l [3] = '{0, 0, 1};
      int          idx_l [3] = '{1, 2, 2};
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, d_t[i]);
         @(posedge clk); #1;
         e = sb0.pop_front(); o = observe(0); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL seq[%0d] got q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b want q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b",
                     i, o.q, o.idx, o.entered, o.dwell, o.fault, o.illegal, e.q, e.idx, e.entered, e.dwell, e.fault, e.illegal);
         end
         checks++;
         if (q_a !== d_t[i] || ent_a !== ent_l[i] || int'(dwell_a) != dw_l[i] || int'(idx_a) != idx_l[i]) begin
            errors++;
            $display("FAIL seq_plan[%0d] got q=%h ent=%b dw=%0d idx=%0d want q=%h ent=%b dw=%0d idx=%0d",
                     i, q_a, ent_a, dwell_a, idx_a, d_t[i], ent_l[i], dw_l[i], idx_l[i]);
         end
      end
   endtask

   task automatic test_stall_sat();
      exp_t e, o;
      drive(0, 1, 0, 0, 13'h0010);
      @(posedge clk); #1;
      e = sb0.pop_front(); o = observe(0); checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL stall_entry got q=%h idx=%0d ent=%b dw=%0d want q=%h idx=%0d ent=%b dw=%0d",
                  o.q, o.idx, o.entered, o.dwell, e.q, e.idx, e.entered, e.dwell);
      end
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 13'($urandom));
         @(posedge clk); #1;
         e = sb0.pop_front(); o = observe(0); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL stall[%0d] got q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b want q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b",
                     i, o.q, o.idx, o.entered, o.dwell, o.fault, o.illegal, e.q, e.idx, e.entered, e.dwell, e.fault, e.illegal);
         end
         checks++;
         if (q_a !== 13'h0010 || ent_a !== 1'b0 || int'(dwell_a) != ((i + 1 < 7) ? i + 1 : 7)) begin
            errors++;
            $display("FAIL stall_plan[%0d] got q=%h ent=%b dw=%0d want q=0010 ent=0 dw=%0d",
                     i, q_a, ent_a, dwell_a, (i + 1 < 7) ? i + 1 : 7);
         end
      end
   endtask

   task automatic test_illegal();
      exp_t        e, o;
      bit          en_t [7]  = '{1, 0, 1, 1, 0, 0, 1};
      bit          clr_t [7] = '{0, 1, 0, 0, 0, 1, 0};
      logic [12:0] d_t [7]   = '{13'h0006, 13'h0000, 13'h0008, 13'h0000, 13'h0000, 13'h0000, 13'h1fff};
      for (int i = 0; i < 7; i++) begin
         drive(0, en_t[i], 0, clr_t[i], d_t[i]);
         @(posedge clk); #1;
         e = sb0.pop_front(); o = observe(0); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL illegal[%0d] got q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b want q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b",
                     i, o.q, o.idx, o.entered, o.dwell, o.fault, o.illegal, e.q, e.idx, e.entered, e.dwell, e.fault, e.illegal);
         end
      end
   endtask

   task automatic test_priority();
      exp_t        e, o;
      bit          en_t [7]  = '{1, 1, 1, 1, 1, 0, 1};
      bit          fl_t [7]  = '{0, 0, 1, 0, 0, 1, 1};
      bit          clr_t [7] = '{0, 0, 0, 1, 0, 1, 0};
      logic [12:0] d_t [7]   = '{13'h0003, 13'h0040, 13'h0003, 13'h000c, 13'h0001, 13'h0000, 13'h0080};
      for (int i = 0; i < 7; i++) begin
         drive(0, en_t[i], fl_t[i], clr_t[i], d_t[i]);
         @(posedge clk); #1;
         e = sb0.pop_front(); o = observe(0); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL priority[%0d] got q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b want q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b",
                     i, o.q, o.idx, o.entered, o.dwell, o.fault, o.illegal, e.q, e.idx, e.entered, e.dwell, e.fault, e.illegal);
         end
      end
   endtask

   task automatic test_params();
      exp_t        e, o;
      bit          en_t [5] = '{1, 1, 0, 1, 0};
      bit          fl_t [5] = '{0, 0, 0, 0, 1};
      logic [12:0] d_t [5]  = '{13'h0001, 13'h0006, 13'h0000, 13'h0010, 13'h0000};
      int          reps [5] = '{1, 1, 20, 1, 1};
      preset_a = 1'b1;
      model_reset(0);
      checks++;
      if ({q_b, idx_b, dwell_b, ill_b, ent_b, flt_b} !== {5'b01000, 3'd3, 8'd0, 3'b000}) begin
         errors++;
         $display("FAIL params_reset got q=%b idx=%0d dw=%0d ill=%b want q=01000 idx=3 dw=0 ill=0", q_b, idx_b, dwell_b, ill_b);
      end
      preset_b = 1'b0;
      model_reset(1);
      for (int i = 0; i < 5; i++) begin
         for (int r = 0; r < reps[i]; r++) begin
            drive(1, en_t[i], fl_t[i], 0, d_t[i]);
            @(posedge clk); #1;
            e = sb1.pop_front(); o = observe(1); checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL params[%0d.%0d] got q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b want q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b",
                        i, r, o.q, o.idx, o.entered, o.dwell, o.fault, o.illegal, e.q, e.idx, e.entered, e.dwell, e.fault, e.illegal);
            end
         end
         if (i == 1) begin
            checks++;
            if (q_b !== 5'b01000 || idx_b !== 3'd3 || flt_b !== 1'b1) begin
               errors++;
               $display("FAIL params_recovery got q=%b idx=%0d flt=%b want q=01000 idx=3 flt=1", q_b, idx_b, flt_b);
            end
         end
      end
      for (int i = 0; i < 260; i++) begin
         drive(1, 0, 0, 0, 13'h0000);
         @(posedge clk); #1;
         e = sb1.pop_front(); o = observe(1); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL params_sat[%0d] got q=%h dw=%0d ent=%b want q=%h dw=%0d ent=%b",
                     i, o.q, o.dwell, o.entered, e.q, e.dwell, e.entered);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e, o;
      logic [12:0] dv;
      preset_a = 1'b0;
      for (int i = 0; i < 300; i++) begin
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 3) != 0) dv = 13'(1) << $urandom_range(0, (k == 0) ? 12 : 4);
            else dv = 13'($urandom) & ((k == 0) ? 13'h1fff : 13'h001f);
            drive(k, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) == 0), dv);
         end
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            if (k == 0) e = sb0.pop_front();
            else e = sb1.pop_front();
            o = observe(k); checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL b2b[%0d] inst=%0d got q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b want q=%h idx=%0d ent=%b dw=%0d flt=%b ill=%b",
                        i, k, o.q, o.idx, o.entered, o.dwell, o.fault, o.illegal, e.q, e.idx, e.entered, e.dwell, e.fault, e.illegal);
            end
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_sequence();
      test_stall_sat();
      test_illegal();
      test_priority();
      test_params();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t, errors=%0d checks=%0d", $time, errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/onehot_state_reg.md
# onehot_state_reg

Parametrised one-hot state register for the control unit's M machine: holds the current micro-state, loads the next-state vector from the next-state logic, and returns to the instruction-fetch state on reset or flush. Adds what the fixed 13-bit register lacks: advance enable for stalls, one-hot integrity checking with automatic recovery, a registered binary state index, a state-entry pulse and a saturating dwell counter for debug and performance monitoring.

## Interface

- N_STATES, 13, number of states / width of the one-hot vector (≥2)
- RESET_IDX, 0, bit index of the reset state (IF); 0 ≤ RESET_IDX < N_STATES
- CNT_W, 8, width of the dwell counter
- IDX_W, $clog2(N_STATES), width of the binary index (derived, not overridden)
- clk  in  1  clock; all state changes on rising edge
- preset  in  1  reset; asynchronous, active-high; forces reset values immediately
- en  in  1  advance: load d this cycle; 0 = hold (stall)
- flush  in  1  synchronous return to RESET_IDX state, overrides en
- clr_err  in  1  clears the sticky illegal flag
- d  in  N_STATES  next-state vector from next-state logic
- q  out  N_STATES  current state, one-hot
- state_idx  out  IDX_W  binary index of the set bit of q
- entered  out  1  one-cycle pulse: q was written this cycle by flush, recovery, or an en load that changed q
- dwell  out  CNT_W  cycles since last entry, saturating
- fault  out  1  one-cycle pulse: illegal d was rejected
- illegal  out  1  sticky: an illegal d has been rejected since last clear

## Operation

- Reset (preset=1, asynchronous): q = one-hot at RESET_IDX, state_idx = RESET_IDX, entered = 0, dwell = 0, fault = 0, illegal = 0.
- Legal d: exactly one bit set. Illegal: zero bits or ≥2 bits set.
- Per rising edge, priority order:
  - flush=1: q ← RESET_IDX one-hot; entered ← 1; dwell ← 0; fault ← 0; d and en ignored (no fault even if d illegal).
  - else en=1, d legal: q ← d; if d ≠ q: entered ← 1, dwell ← 0; else entered ← 0, dwell increments.
  - else en=1, d illegal: q ← RESET_IDX one-hot (recovery); entered ← 1; dwell ← 0; fault ← 1; illegal ← 1.
  - else (en=0): q holds; entered ← 0; dwell increments.
- fault is 0 on every cycle not matching the recovery case.
- dwell increment saturates at 2^CNT_W−1; never wraps.
- illegal: set by recovery; cleared by clr_err=1 only when no recovery occurs the same cycle (set wins).
- state_idx registered together with q; always equals index of q's set bit; never reflects an illegal d.
- q is one-hot at all times after reset; no output ever shows zero or multiple bits.

## Timing

- Load latency 1 cycle: d sampled on edge k appears on q after edge k.
- entered, fault, dwell, state_idx update on the same edge as q; all registered outputs, no combinational path from inputs to outputs.
- preset assertion clears outputs asynchronously mid-cycle; release synchronised externally; first load on the first edge with preset=0.
- Stalled (en=0) for any number of cycles: q, state_idx constant; dwell keeps counting to saturation.

## Test plan

- Reset: assert preset mid-cycle with q=bit 5 → q=13'b0000000000001, state_idx=0, dwell=0, illegal=0 without a clock edge.
- Sequence: en=1, d = bit 1, bit 2, bit 2 on three edges → q follows 1 cycle late; entered = 1,1,0; dwell = 0,0,1; state_idx = 1,2,2.
- Stall/saturation: CNT_W=3, hold en=0 for 10 cycles → q unchanged, dwell 1..7 then stays 7; entered=0 throughout.
- Illegal d: en=1, d=13'b0000000000110 → q=RESET_IDX one-hot, fault=1 for one cycle, illegal=1 sticky; next cycle clr_err=1 → illegal=0; d=0 likewise recovers.
- Priority: flush=1 with en=1, d=13'b11 → q=RESET_IDX, entered=1, fault=0, illegal unchanged; recovery and clr_err same edge → illegal stays 1.
- Parameters: N_STATES=5, RESET_IDX=3 → reset q=5'b01000, state_idx=3; recovery lands on bit 3.
